// File: rtl/common_dffcam_alloc_ctrl_pkg.sv
// Shared types for the DFF-CAM allocation controller: FSM states and request op encoding.
package common_dffcam_alloc_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLookup = 3'd1,
    StWrite  = 3'd2,
    StResp   = 3'd3,
    StFlush  = 3'd4
  } state_e;

  localparam logic OpInsert = 1'b0;
  localparam logic OpRemove = 1'b1;

endpackage

// File: rtl/common_dffcam_alloc_ctrl_encoder.sv
// LSB-first free-slot finder: index of the lowest clear bit in the valid vector.
module macro_encoder_first_zero #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0]         valid_i,
  output logic [$clog2(Width)-1:0] index_o,
  output logic                     any_free_o
);

  always_comb begin
    index_o    = '0;
    any_free_o = 1'b0;
    // Scan downward so the lowest free index is the last one assigned.
    for (int i = int'(Width) - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        index_o    = ($clog2(Width))'(i);
        any_free_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/common_dffcam_alloc_ctrl.sv
// Insert/remove/flush controller for a DFF-based CAM; keeps a shadow valid map,
// occupancy count and a round-robin eviction pointer.
module common_dffcam_alloc_ctrl
  import common_dffcam_alloc_ctrl_pkg::*;
#(
  parameter int unsigned CAM_DEPTH = 8,
  parameter int unsigned CAM_WIDTH = 16,
  localparam int unsigned AW = $clog2(CAM_DEPTH),
  localparam int unsigned OW = $clog2(CAM_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_op,
  input  logic [CAM_WIDTH-1:0] req_key,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_hit,
  output logic [AW-1:0]        rsp_addr,
  output logic                 rsp_evict,
  input  logic                 flush,
  output logic [OW-1:0]        occupancy,
  output logic [AW-1:0]        cam_addr,
  output logic                 cam_en,
  output logic                 cam_we,
  output logic [CAM_WIDTH-1:0] cam_din,
  output logic                 cam_din_valid,
  output logic [CAM_WIDTH-1:0] cam_qdata,
  input  logic [AW-1:0]        cam_qaddr,
  input  logic                 cam_qvalid
);

  state_e               state_q, state_d;
  logic                 op_q, op_d;
  logic [CAM_WIDTH-1:0] key_q, key_d;
  logic [AW-1:0]        target_q, target_d;
  logic                 hit_q, hit_d;
  logic                 evict_q, evict_d;
  logic [AW-1:0]        rr_q, rr_d;
  logic [AW-1:0]        sweep_q, sweep_d;
  logic [OW-1:0]        occ_q, occ_d;
  logic [CAM_DEPTH-1:0] valid_q, valid_d;

  logic [AW-1:0] free_idx;
  logic          any_free;

  macro_encoder_first_zero #(
    .Width(CAM_DEPTH)
  ) u_free (
    .valid_i   (valid_q),
    .index_o   (free_idx),
    .any_free_o(any_free)
  );

  assign occupancy = occ_q;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    key_d         = key_q;
    target_d      = target_q;
    hit_d         = hit_q;
    evict_d       = evict_q;
    rr_d          = rr_q;
    sweep_d       = sweep_q;
    occ_d         = occ_q;
    valid_d       = valid_q;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_hit       = 1'b0;
    rsp_addr      = '0;
    rsp_evict     = 1'b0;
    cam_en        = 1'b0;
    cam_we        = 1'b0;
    cam_addr      = target_q;
    cam_din       = key_q;
    cam_din_valid = 1'b0;
    cam_qdata     = key_q;

    unique case (state_q)
      StIdle: begin
        // Don't accept a request in the same cycle a flush would drop it.
        req_ready = !flush;
        if (req_valid && !flush) begin
          op_d    = req_op;
          key_d   = req_key;
          state_d = StLookup;
        end
      end
      StLookup: begin
        hit_d   = 1'b0;
        evict_d = 1'b0;
        if (op_q == OpInsert) begin
          if (cam_qvalid) begin
            hit_d    = 1'b1;
            target_d = cam_qaddr;
            state_d  = StResp;
          end else if (any_free) begin
            target_d = free_idx;
            state_d  = StWrite;
          end else begin
            target_d = rr_q;
            evict_d  = 1'b1;
            rr_d     = rr_q + AW'(1);
            state_d  = StWrite;
          end
        end else begin
          if (cam_qvalid) begin
            hit_d    = 1'b1;
            target_d = cam_qaddr;
            state_d  = StWrite;
          end else begin
            target_d = '0;
            state_d  = StResp;
          end
        end
      end
      StWrite: begin
        cam_en            = 1'b1;
        cam_we            = 1'b1;
        cam_din_valid     = (op_q == OpInsert);
        valid_d[target_q] = (op_q == OpInsert);
        if (op_q == OpRemove) begin
          occ_d = occ_q - OW'(1);
        end else if (!evict_q) begin
          occ_d = occ_q + OW'(1);
        end
        state_d = StResp;
      end
      StResp: begin
        rsp_valid = 1'b1;
        rsp_hit   = hit_q;
        rsp_addr  = target_q;
        rsp_evict = evict_q;
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      StFlush: begin
        cam_en   = 1'b1;
        cam_we   = 1'b1;
        cam_addr = sweep_q;
        sweep_d  = sweep_q + AW'(1);
        if (sweep_q == AW'(CAM_DEPTH - 1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Flush overrides everything, including a sweep already in progress.
    if (flush) begin
      state_d = StFlush;
      sweep_d = '0;
      valid_d = '0;
      rr_d    = '0;
      occ_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= OpInsert;
      key_q    <= '0;
      target_q <= '0;
      hit_q    <= 1'b0;
      evict_q  <= 1'b0;
      rr_q     <= '0;
      sweep_q  <= '0;
      occ_q    <= '0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      key_q    <= key_d;
      target_q <= target_d;
      hit_q    <= hit_d;
      evict_q  <= evict_d;
      rr_q     <= rr_d;
      sweep_q  <= sweep_d;
      occ_q    <= occ_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_common_dffcam_alloc_ctrl.sv
// Bench for common_dffcam_alloc_ctrl with an attached model CAM and a set-level reference model.
module tb_common_dffcam_alloc_ctrl;
  localparam int unsigned D  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned AW = 2;
  localparam int unsigned OW = 3;

  logic          clk = 1'b0;
  logic          reset, req_valid, req_ready, req_op;
  logic [W-1:0]  req_key;
  logic          rsp_valid, rsp_ready, rsp_hit, rsp_evict, flush;
  logic [AW-1:0] rsp_addr, cam_addr, cam_qaddr;
  logic [OW-1:0] occupancy;
  logic          cam_en, cam_we, cam_din_valid, cam_qvalid;
  logic [W-1:0]  cam_din, cam_qdata;

  int vectors = 0;
  int miscompares = 0;

  common_dffcam_alloc_ctrl #(.CAM_DEPTH(D), .CAM_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_key(req_key), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_addr(rsp_addr), .rsp_evict(rsp_evict), .flush(flush), .occupancy(occupancy),
    .cam_addr(cam_addr), .cam_en(cam_en), .cam_we(cam_we), .cam_din(cam_din),
    .cam_din_valid(cam_din_valid), .cam_qdata(cam_qdata), .cam_qaddr(cam_qaddr),
    .cam_qvalid(cam_qvalid)
  );

  always #5 clk = ~clk;

  // Attached storage CAM.
  logic [W-1:0] mk [D];
  logic [D-1:0] mv;
  always @(posedge clk) begin
    if (reset) mv <= '0;
    else if (cam_en && cam_we) begin
      mk[cam_addr] <= cam_din;
      mv[cam_addr] <= cam_din_valid;
    end
  end
  always_comb begin
    cam_qvalid = 1'b0;
    cam_qaddr  = '0;
    for (int i = D - 1; i >= 0; i--) begin
      if (mv[i] && mk[i] == cam_qdata) begin
        cam_qvalid = 1'b1;
        cam_qaddr  = AW'(i);
      end
    end
  end

  // Write log.
  int           wr_total = 0;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_din;
  logic          wr_dv;
  always @(negedge clk) begin
    if (cam_en && cam_we) begin
      wr_total = wr_total + 1;
      wr_addr  = cam_addr;
      wr_din   = cam_din;
      wr_dv    = cam_din_valid;
    end
  end

  // Reference model: slots holding keys, round-robin pointer and count.
  logic [W-1:0] rk [D];
  bit           rv [D];
  int           rr, cnt;

  task automatic model_clear();
    for (int i = 0; i < D; i++) rv[i] = 1'b0;
    rr  = 0;
    cnt = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic op, input logic [W-1:0] key, input int hold);
    int hit_i, slot, lat, exp_lat, exp_addr, wr0;
    bit exp_hit, exp_evict, exp_wr;
    logic [AW-1:0] a0;
    logic h0, e0;
    hit_i = -1;
    for (int i = 0; i < D; i++) if (rv[i] && rk[i] == key && hit_i < 0) hit_i = i;
    exp_evict = 0;
    exp_wr    = 0;
    exp_hit   = (hit_i >= 0);
    exp_addr  = 0;
    if (op == 1'b0) begin
      if (exp_hit) exp_addr = hit_i;
      else begin
        exp_wr = 1;
        slot   = -1;
        for (int i = 0; i < D; i++) if (!rv[i] && slot < 0) slot = i;
        if (slot < 0) begin
          slot      = rr;
          rr        = (rr + 1) % D;
          exp_evict = 1;
        end else cnt++;
        exp_addr = slot;
        rk[slot] = key;
        rv[slot] = 1'b1;
      end
    end else if (exp_hit) begin
      exp_addr  = hit_i;
      exp_wr    = 1;
      rv[hit_i] = 1'b0;
      cnt--;
    end
    exp_lat = exp_wr ? 3 : 2;

    check("req_ready_idle", req_ready, 1);
    wr0       = wr_total;
    req_valid = 1'b1;
    req_op    = op;
    req_key   = key;
    @(negedge clk);
    req_valid = 1'b0;
    lat       = 1;
    check("req_ready_busy", req_ready, 0);
    while (!rsp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, exp_lat);
    check("rsp_hit", rsp_hit, exp_hit);
    check("rsp_addr", rsp_addr, exp_addr);
    check("rsp_evict", rsp_evict, exp_evict);
    a0 = rsp_addr;
    h0 = rsp_hit;
    e0 = rsp_evict;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      check("hold_stable", {rsp_valid, req_ready, rsp_hit, rsp_evict, rsp_addr},
            {1'b1, 1'b0, h0, e0, a0});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_done", {rsp_valid, req_ready}, 2'b01);
    check("wr_count", wr_total - wr0, exp_wr);
    if (exp_wr) begin
      check("wr_addr", wr_addr, exp_addr);
      check("wr_din", wr_din, key);
      check("wr_dv", wr_dv, (op == 1'b0));
    end
    check("occupancy", occupancy, cnt);
  endtask

  task automatic sweep_check(input int from);
    logic [AW-1:0] ai;
    for (int i = from; i < D; i++) begin
      ai = AW'(i);
      check("sweep_write", {cam_en, cam_we, cam_din_valid, cam_addr, rsp_valid, req_ready},
            {1'b1, 1'b1, 1'b0, ai, 1'b0, 1'b0});
      @(negedge clk);
    end
    check("flush_done", {req_ready, cam_en, occupancy}, {1'b1, 1'b0, OW'(0)});
    model_clear();
  endtask

  task automatic flush_idle();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    sweep_check(0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 1'b0;
    req_key   = '0;
    rsp_ready = 1'b0;
    flush     = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_state",
          {req_ready, rsp_valid, rsp_hit, rsp_evict, rsp_addr, occupancy, cam_en, cam_we},
          {1'b1, 1'b0, 1'b0, 1'b0, AW'(0), OW'(0), 1'b0, 1'b0});

    do_req(1'b0, 8'h11, 0);
    do_req(1'b0, 8'h22, 0);
    do_req(1'b0, 8'h22, 0);
    do_req(1'b0, 8'h33, 0);
    do_req(1'b0, 8'h44, 0);
    do_req(1'b0, 8'h55, 0);
    do_req(1'b0, 8'h66, 0);
    do_req(1'b1, 8'h33, 0);
    do_req(1'b0, 8'h77, 0);
    do_req(1'b1, 8'h99, 5);

    // Flush while a full-CAM insert is in its WRITE cycle.
    req_valid = 1'b1;
    req_op    = 1'b0;
    req_key   = 8'h88;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("in_write", {cam_en, cam_we}, 2'b11);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    sweep_check(0);

    do_req(1'b0, 8'h11, 0);
    do_req(1'b0, 8'h22, 0);

    // Reset part-way through a sweep.
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("sweep0", {cam_en, cam_addr}, {1'b1, AW'(0)});
    @(negedge clk);
    check("sweep1", {cam_en, cam_addr}, {1'b1, AW'(1)});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_mid_sweep", {req_ready, rsp_valid, cam_en, occupancy},
          {1'b1, 1'b0, 1'b0, OW'(0)});
    @(negedge clk);
    check("no_write_after_reset", cam_en, 0);
    model_clear();

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 14) == 0) flush_idle();
      else do_req(1'($urandom_range(0, 1)), 8'(8'h10 + $urandom_range(0, 5)),
                  int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
